// File: rtl/dbg_probe_scanner.sv
// dbg_probe_scanner
//   Board-side reader for the CPU debug interface. It keeps an index register
//   that drives the register-file and data-memory debug addresses, captures the
//   value selected by mode_sel every clock, optionally keeps pipeline event
//   statistics, and scans the captured 32-bit value as 8 hex digits onto a
//   multiplexed, active-low 7-segment display.
//
// Configuration macro:
//   DBG_SCANNER_STATS_EN  defined   -> four 32-bit event counters, shown in modes 4-7
//                         undefined -> no counters, modes 4-7 show 32'd0
//
// Parameters:
//   DmAddrBit  width of datamem_addr_dbg (word address, >= 5)
//   ScanDiv    clk cycles each digit stays lit (>= 2)
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   mode_sel[2:0]           0 display,1 pc,2 regfile,3 datamem,4 cycles,5 jumps,6 branches,7 bubbles
//   idx_up, idx_down        1-cycle pre-debounced pulses stepping the index
//   cpu_en                  CPU enable (qualifies all statistics)
//   halted, jumped, branched, bubble   CPU status flags
//   pc_dbg, regfile_data_dbg, datamem_data_dbg, display   CPU debug data
//   regfile_req_dbg[4:0]    register index to CPU
//   datamem_addr_dbg        data memory word address to CPU
//   shown_value[31:0]       value currently displayed
//   seg_an[7:0]             digit anodes, active-low, bit0 = rightmost digit
//   seg_cat[7:0]            cathodes {dp,g..a}, active-low, dp always off

`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 10
`endif

module dbg_probe_scanner #(
  parameter int DmAddrBit = `DM_ADDR_BIT,
  parameter int ScanDiv   = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           mode_sel,
  input  logic                 idx_up,
  input  logic                 idx_down,
  input  logic                 cpu_en,
  input  logic                 halted,
  input  logic                 jumped,
  input  logic                 branched,
  input  logic                 bubble,
  input  logic [31:0]          pc_dbg,
  input  logic [31:0]          regfile_data_dbg,
  input  logic [31:0]          datamem_data_dbg,
  input  logic [31:0]          display,
  output logic [4:0]           regfile_req_dbg,
  output logic [DmAddrBit-1:0] datamem_addr_dbg,
  output logic [31:0]          shown_value,
  output logic [7:0]           seg_an,
  output logic [7:0]           seg_cat
);

  typedef enum logic [2:0] {
    MODE_DISPLAY  = 3'd0,
    MODE_PC       = 3'd1,
    MODE_REGFILE  = 3'd2,
    MODE_DATAMEM  = 3'd3,
    MODE_CYCLES   = 3'd4,
    MODE_JUMPS    = 3'd5,
    MODE_BRANCHES = 3'd6,
    MODE_BUBBLES  = 3'd7
  } mode_e;

  localparam int DivW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;

  mode_e                mode;
  mode_e                prev_mode;
  logic [DmAddrBit-1:0] index;
  logic [DmAddrBit-1:0] index_next;
  logic [4:0]           reg_step;
  logic [31:0]          stat_value;
  logic [31:0]          capture;
  logic [DivW-1:0]      div;
  logic [2:0]           digit;

  assign mode = mode_e'(mode_sel);

  // ---------------- index stepping ----------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    index_next = index;
    reg_step   = idx_up ? index[4:0] + 5'd1 : index[4:0] - 5'd1;
    if (mode != prev_mode) begin
      // A mode switch restarts browsing; a pulse in the same cycle is dropped.
      index_next = '0;
    end else if (idx_up ^ idx_down) begin
      case (mode)
        MODE_REGFILE: index_next = DmAddrBit'(reg_step);  // 5-bit wrap, upper bits cleared
        MODE_DATAMEM: index_next = idx_up ? index + DmAddrBit'(1) : index - DmAddrBit'(1);
        default:      index_next = index;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= '0;
      prev_mode <= MODE_DISPLAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      index     <= index_next;
      prev_mode <= mode;
    end
  end

  // The index register is itself the registered request seen by the CPU.
  assign regfile_req_dbg  = index[4:0];
  assign datamem_addr_dbg = index;

  // ---------------- statistics ----------------
`ifdef DBG_SCANNER_STATS_EN
  logic [31:0] cnt_cycles, cnt_jumps, cnt_branches, cnt_bubbles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cycles   <= '0;
      cnt_jumps    <= '0;
      cnt_branches <= '0;
      cnt_bubbles  <= '0;
    end else if (cpu_en) begin
      // halted freezes only the cycle and bubble counts.
      if (!halted)           cnt_cycles   <= cnt_cycles + 32'd1;
      if (jumped)            cnt_jumps    <= cnt_jumps + 32'd1;
      if (branched)          cnt_branches <= cnt_branches + 32'd1;
      if (bubble && !halted) cnt_bubbles  <= cnt_bubbles + 32'd1;
    end
  end

  always_comb begin
    stat_value = '0;
    case (mode)
      MODE_CYCLES:   stat_value = cnt_cycles;
      MODE_JUMPS:    stat_value = cnt_jumps;
      MODE_BRANCHES: stat_value = cnt_branches;
      MODE_BUBBLES:  stat_value = cnt_bubbles;
      default:       stat_value = '0;
    endcase
  end
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = &{cpu_en, halted, jumped, branched, bubble};
  assign stat_value         = '0;
`endif

  // ---------------- capture ----------------
  always_comb begin
    capture = stat_value;
    case (mode)
      MODE_DISPLAY: capture = display;
      MODE_PC:      capture = pc_dbg;
      MODE_REGFILE: capture = regfile_data_dbg;
      MODE_DATAMEM: capture = datamem_data_dbg;
      default:      capture = stat_value;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shown_value <= '0;
    else        shown_value <= capture;
  end

  // ---------------- display scan ----------------
  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex7seg = 8'hC0;  4'h1: hex7seg = 8'hF9;
      4'h2: hex7seg = 8'hA4;  4'h3: hex7seg = 8'hB0;
      4'h4: hex7seg = 8'h99;  4'h5: hex7seg = 8'h92;
      4'h6: hex7seg = 8'h82;  4'h7: hex7seg = 8'hF8;
      4'h8: hex7seg = 8'h80;  4'h9: hex7seg = 8'h90;
      4'hA: hex7seg = 8'h88;  4'hB: hex7seg = 8'h83;
      4'hC: hex7seg = 8'hC6;  4'hD: hex7seg = 8'hA1;
      4'hE: hex7seg = 8'h86;  default: hex7seg = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      digit   <= '0;
      seg_an  <= 8'hFE;
      seg_cat <= 8'hC0;
    end else begin
      if (div == DivW'(ScanDiv - 1)) begin
        div   <= '0;
        digit <= digit + 3'd1;   // 7 -> 0 by natural overflow
      end else begin
        div <= div + DivW'(1);
      end
      // Drive pins from the current digit and captured value; one clock behind the counters.
      seg_an  <= ~(8'b1 << digit);
      seg_cat <= hex7seg(shown_value[{digit, 2'b00} +: 4]);
    end
  end

endmodule
